// File: rtl/mem_arbiter.sv
// Arbitrates the single main-memory port between the icache and dcache miss paths.
// One line transfer (request + BEATS data beats) is in flight at a time; ties go round-robin.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int BEATS  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  output logic              ic_resp_valid,
  output logic [DATA_W-1:0] ic_resp_data,
  input  logic              dc_req_valid,
  input  logic              dc_req_rw,
  input  logic [ADDR_W-1:0] dc_req_addr,
  output logic              dc_req_ready,
  input  logic              dc_wdata_valid,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_wdata_ready,
  output logic              dc_resp_valid,
  output logic [DATA_W-1:0] dc_resp_data,
  output logic              mem_req_valid,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  output logic              mem_wdata_valid,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_wdata_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              busy
);

  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, WDATA, RDATA} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              grant_dc, grant_dc_nxt;
  logic              last_dc, last_dc_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic              rw_q, rw_nxt;
  logic              pick_dc;

  // dcache wins when alone, or on a tie when the icache was served last
  assign pick_dc = dc_req_valid && (!ic_req_valid || !last_dc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      grant_dc <= 1'b0;
      last_dc  <= 1'b0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      grant_dc <= grant_dc_nxt;
      last_dc  <= last_dc_nxt;
      addr_q   <= addr_nxt;
      rw_q     <= rw_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    grant_dc_nxt    = grant_dc;
    last_dc_nxt     = last_dc;
    addr_nxt        = addr_q;
    rw_nxt          = rw_q;
    mem_req_valid   = 1'b0;
    ic_req_ready    = 1'b0;
    dc_req_ready    = 1'b0;
    mem_wdata_valid = 1'b0;
    dc_wdata_ready  = 1'b0;
    ic_resp_valid   = 1'b0;
    dc_resp_valid   = 1'b0;

    case (state)
      IDLE: begin
        if (ic_req_valid || dc_req_valid) begin
          grant_dc_nxt = pick_dc;
          last_dc_nxt  = pick_dc;
          addr_nxt     = pick_dc ? dc_req_addr : ic_req_addr;
          rw_nxt       = pick_dc && dc_req_rw;
          state_nxt    = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        ic_req_ready  = !grant_dc && mem_req_ready;
        dc_req_ready  = grant_dc && mem_req_ready;
        if (mem_req_ready) begin
          cnt_nxt   = '0;
          state_nxt = rw_q ? WDATA : RDATA;
        end
      end
      WDATA: begin
        mem_wdata_valid = dc_wdata_valid;
        dc_wdata_ready  = mem_wdata_ready;
        if (dc_wdata_valid && mem_wdata_ready) begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST_BEAT) state_nxt = IDLE;
        end
      end
      RDATA: begin
        ic_resp_valid = !grant_dc && mem_resp_valid;
        dc_resp_valid = grant_dc && mem_resp_valid;
        if (mem_resp_valid) begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST_BEAT) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Data paths are plain wires; only the valids/readies are gated by state
  assign mem_req_rw   = rw_q;
  assign mem_req_addr = addr_q;
  assign mem_wdata    = dc_wdata;
  assign ic_resp_data = mem_resp_data;
  assign dc_resp_data = mem_resp_data;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-by-cycle read table plus hand sequences
// for round-robin alternation, write stalls, request stalls and mid-burst reset.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ic_req_valid, ic_req_ready, ic_resp_valid;
  logic [27:0]  ic_req_addr;
  logic [127:0] ic_resp_data;
  logic         dc_req_valid, dc_req_rw, dc_req_ready;
  logic [27:0]  dc_req_addr;
  logic         dc_wdata_valid, dc_wdata_ready, dc_resp_valid;
  logic [127:0] dc_wdata, dc_resp_data;
  logic         mem_req_valid, mem_req_rw, mem_req_ready;
  logic [27:0]  mem_req_addr;
  logic         mem_wdata_valid, mem_wdata_ready, mem_resp_valid;
  logic [127:0] mem_wdata, mem_resp_data;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_rw(dc_req_rw), .dc_req_addr(dc_req_addr),
    .dc_req_ready(dc_req_ready), .dc_wdata_valid(dc_wdata_valid), .dc_wdata(dc_wdata),
    .dc_wdata_ready(dc_wdata_ready), .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_wdata_valid(mem_wdata_valid), .mem_wdata(mem_wdata),
    .mem_wdata_ready(mem_wdata_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .busy(busy)
  );

  typedef struct {
    logic         icv;
    logic [27:0]  ica;
    logic         dcv;
    logic [27:0]  dca;
    logic         mrdy;
    logic         rv;
    logic [127:0] rd;
    logic         e_mreq;
    logic [27:0]  e_addr;
    logic         e_icr;
    logic         e_dcr;
    logic         e_icrsp;
    logic         e_dcrsp;
    logic         e_busy;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic icv, input logic [27:0] ica, input logic dcv,
                              input logic [27:0] dca, input logic mrdy, input logic rv,
                              input logic [127:0] rd, input logic e_mreq, input logic [27:0] e_addr,
                              input logic e_icr, input logic e_dcr, input logic e_icrsp,
                              input logic e_dcrsp, input logic e_busy);
    vec_t v;
    v.icv = icv; v.ica = ica; v.dcv = dcv; v.dca = dca; v.mrdy = mrdy; v.rv = rv; v.rd = rd;
    v.e_mreq = e_mreq; v.e_addr = e_addr; v.e_icr = e_icr; v.e_dcr = e_dcr;
    v.e_icrsp = e_icrsp; v.e_dcrsp = e_dcrsp; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    ic_req_valid   = v.icv;
    ic_req_addr    = v.ica;
    dc_req_valid   = v.dcv;
    dc_req_addr    = v.dca;
    dc_req_rw      = 1'b0;
    mem_req_ready  = v.mrdy;
    mem_resp_valid = v.rv;
    mem_resp_data  = v.rd;
  endtask

  task automatic clearInputs();
    ic_req_valid = 0; ic_req_addr = '0; dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0;
    dc_wdata_valid = 0; dc_wdata = '0; mem_req_ready = 0; mem_wdata_ready = 0;
    mem_resp_valid = 0; mem_resp_data = '0;
  endtask

  // Waits (bounded) for the next memory request, checks who got it and after how many idle cycles,
  // then feeds four read beats with the responses routed to the granted side only.
  task automatic serveRead(input bit exp_dc, input logic [27:0] exp_addr);
    int waited = 0;
    bit found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      #1;
      if (mem_req_valid) found = 1;
      else begin
        waited++;
        @(negedge clk);
      end
    end
    checkOutput("rr grant seen", found, 1);
    if (found) begin
      checkOutput("rr idle gap", waited, 1);
      checkOutput("rr dc_req_ready", dc_req_ready, exp_dc);
      checkOutput("rr ic_req_ready", ic_req_ready, !exp_dc);
      checkOutput("rr addr", mem_req_addr, exp_addr);
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        mem_resp_valid = 1;
        mem_resp_data  = 128'(b + 7);
        #1;
        checkOutput("rr ic_resp_valid", ic_resp_valid, !exp_dc);
        checkOutput("rr dc_resp_valid", dc_resp_valid, exp_dc);
      end
      @(negedge clk);
      mem_resp_valid = 0;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idx, stall;
    logic exp_wrdy;

    tbl[0]  = mk(1, 28'h0000100, 0, 0,          0, 0, 0,       0, 0,          0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 28'h0000100, 0, 0,          1, 0, 0,       1, 28'h0000100, 1, 0, 0, 0, 1);
    tbl[2]  = mk(0, 0,           0, 0,          0, 1, 128'hD0, 0, 0,          0, 0, 1, 0, 1);
    tbl[3]  = mk(0, 0,           0, 0,          0, 1, 128'hD1, 0, 0,          0, 0, 1, 0, 1);
    tbl[4]  = mk(0, 0,           0, 0,          0, 1, 128'hD2, 0, 0,          0, 0, 1, 0, 1);
    tbl[5]  = mk(0, 0,           0, 0,          0, 1, 128'hD3, 0, 0,          0, 0, 1, 0, 1);
    tbl[6]  = mk(0, 0,           0, 0,          0, 0, 0,       0, 0,          0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 28'h0000200, 1, 28'h0000300, 0, 0, 0,       0, 0,          0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 28'h0000200, 1, 28'h0000300, 1, 0, 0,       1, 28'h0000300, 0, 1, 0, 0, 1);
    tbl[9]  = mk(1, 28'h0000200, 0, 0,          1, 1, 128'hE0, 0, 0,          0, 0, 0, 1, 1);
    tbl[10] = mk(1, 28'h0000200, 0, 0,          1, 1, 128'hE1, 0, 0,          0, 0, 0, 1, 1);
    tbl[11] = mk(1, 28'h0000200, 0, 0,          1, 1, 128'hE2, 0, 0,          0, 0, 0, 1, 1);
    tbl[12] = mk(1, 28'h0000200, 0, 0,          1, 1, 128'hE3, 0, 0,          0, 0, 0, 1, 1);
    tbl[13] = mk(1, 28'h0000200, 0, 0,          0, 0, 0,       0, 0,          0, 0, 0, 0, 0);
    tbl[14] = mk(1, 28'h0000200, 0, 0,          1, 0, 0,       1, 28'h0000200, 1, 0, 0, 0, 1);
    tbl[15] = mk(0, 0,           0, 0,          0, 1, 128'hF0, 0, 0,          0, 0, 1, 0, 1);
    tbl[16] = mk(0, 0,           0, 0,          0, 1, 128'hF1, 0, 0,          0, 0, 1, 0, 1);
    tbl[17] = mk(0, 0,           0, 0,          0, 1, 128'hF2, 0, 0,          0, 0, 1, 0, 1);
    tbl[18] = mk(0, 0,           0, 0,          0, 1, 128'hF3, 0, 0,          0, 0, 1, 0, 1);
    tbl[19] = mk(0, 0,           0, 0,          0, 0, 0,       0, 0,          0, 0, 0, 0, 0);

    // Reset state, with noise on the inputs that must not leak through
    rst_n = 0;
    clearInputs();
    mem_resp_valid = 1;
    dc_wdata_valid = 1;
    mem_wdata_ready = 1;
    mem_req_ready = 1;
    #2;
    checkOutput("reset mem_req_valid", mem_req_valid, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset ic_resp_valid", ic_resp_valid, 0);
    checkOutput("reset dc_resp_valid", dc_resp_valid, 0);
    checkOutput("reset dc_wdata_ready", dc_wdata_ready, 0);
    checkOutput("reset mem_wdata_valid", mem_wdata_valid, 0);
    checkOutput("reset ic_req_ready", ic_req_ready, 0);
    checkOutput("reset dc_req_ready", dc_req_ready, 0);
    checkOutput("reset addr", mem_req_addr, 0);
    checkOutput("reset rw", mem_req_rw, 0);
    @(negedge clk);
    rst_n = 1;
    clearInputs();

    $display("[TB] table: icache read, tie, deferred icache read");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(tbl[i]);
      #1;
      checkOutput($sformatf("row%0d mem_req_valid", i), mem_req_valid, tbl[i].e_mreq);
      if (tbl[i].e_mreq) begin
        checkOutput($sformatf("row%0d addr", i), mem_req_addr, tbl[i].e_addr);
        checkOutput($sformatf("row%0d rw", i), mem_req_rw, 0);
      end
      checkOutput($sformatf("row%0d ic_req_ready", i), ic_req_ready, tbl[i].e_icr);
      checkOutput($sformatf("row%0d dc_req_ready", i), dc_req_ready, tbl[i].e_dcr);
      checkOutput($sformatf("row%0d ic_resp_valid", i), ic_resp_valid, tbl[i].e_icrsp);
      checkOutput($sformatf("row%0d dc_resp_valid", i), dc_resp_valid, tbl[i].e_dcrsp);
      checkOutput($sformatf("row%0d busy", i), busy, tbl[i].e_busy);
      if (tbl[i].e_icrsp)
        checkOutput($sformatf("row%0d ic_resp_data", i), ic_resp_data, tbl[i].rd);
      if (tbl[i].e_dcrsp)
        checkOutput($sformatf("row%0d dc_resp_data", i), dc_resp_data, tbl[i].rd);
      @(negedge clk);
    end

    $display("[TB] round-robin with both requesters held after reset");
    rst_n = 0;
    clearInputs();
    @(negedge clk);
    rst_n = 1;
    ic_req_valid = 1; ic_req_addr = 28'h0000011;
    dc_req_valid = 1; dc_req_addr = 28'h0000022; dc_req_rw = 0;
    mem_req_ready = 1;
    serveRead(1, 28'h0000022);
    serveRead(0, 28'h0000011);
    serveRead(1, 28'h0000022);
    serveRead(0, 28'h0000011);
    clearInputs();

    $display("[TB] dcache writeback with a write-ready stall on beat 1");
    dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 28'h0ABCDEF;
    dc_wdata_valid = 1; dc_wdata = 128'h5555; mem_wdata_ready = 1; mem_resp_valid = 1;
    #1;
    checkOutput("idle dc_wdata_ready", dc_wdata_ready, 0);
    checkOutput("idle mem_wdata_valid", mem_wdata_valid, 0);
    checkOutput("idle spurious ic_resp", ic_resp_valid, 0);
    checkOutput("idle spurious dc_resp", dc_resp_valid, 0);
    @(negedge clk);
    mem_req_ready = 1;
    #1;
    checkOutput("wb mem_req_valid", mem_req_valid, 1);
    checkOutput("wb rw", mem_req_rw, 1);
    checkOutput("wb addr", mem_req_addr, 28'h0ABCDEF);
    checkOutput("wb dc_req_ready", dc_req_ready, 1);
    @(negedge clk);
    dc_req_valid = 0; mem_req_ready = 0;
    idx = 0; stall = 0;
    for (int k = 0; k < 12 && idx < 4; k++) begin
      dc_wdata = 128'hC0FFEE00 + 128'(idx);
      exp_wrdy = !(idx == 1 && stall < 2);
      mem_wdata_ready = exp_wrdy;
      #1;
      checkOutput("wb mem_wdata_valid", mem_wdata_valid, 1);
      checkOutput("wb mem_wdata", mem_wdata, 128'hC0FFEE00 + 128'(idx));
      checkOutput("wb dc_wdata_ready", dc_wdata_ready, exp_wrdy);
      checkOutput("wb spurious ic_resp", ic_resp_valid, 0);
      checkOutput("wb spurious dc_resp", dc_resp_valid, 0);
      checkOutput("wb busy", busy, 1);
      if (exp_wrdy) idx++;
      else stall++;
      @(negedge clk);
    end
    checkOutput("wb beats delivered", idx, 4);
    #1;
    checkOutput("wb done busy", busy, 0);
    checkOutput("wb done dc_wdata_ready", dc_wdata_ready, 0);
    checkOutput("wb done dc_resp", dc_resp_valid, 0);
    @(negedge clk);
    clearInputs();

    $display("[TB] request stall in REQ, then reset mid-burst");
    ic_req_valid = 1; ic_req_addr = 28'h0123456;
    @(negedge clk);
    for (int c = 1; c <= 3; c++) begin
      #1;
      checkOutput("stall mem_req_valid", mem_req_valid, 1);
      checkOutput("stall addr", mem_req_addr, 28'h0123456);
      checkOutput("stall rw", mem_req_rw, 0);
      checkOutput("stall ic_req_ready", ic_req_ready, 0);
      @(negedge clk);
    end
    mem_req_ready = 1;
    #1;
    checkOutput("stall ready pulse", ic_req_ready, 1);
    @(negedge clk);
    ic_req_valid = 0;
    for (int b = 0; b < 3; b++) begin
      mem_resp_valid = 1; mem_resp_data = 128'hB0 + 128'(b);
      #1;
      checkOutput("burst ic_req_ready", ic_req_ready, 0);
      checkOutput("burst ic_resp_valid", ic_resp_valid, 1);
      @(negedge clk);
    end
    mem_resp_valid = 1; mem_resp_data = 128'hB3;
    #1;
    rst_n = 0;
    #1;
    checkOutput("abort ic_resp_valid", ic_resp_valid, 0);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort mem_req_valid", mem_req_valid, 0);
    checkOutput("abort addr", mem_req_addr, 0);
    @(negedge clk);
    rst_n = 1;
    clearInputs();
    ic_req_valid = 1; ic_req_addr = 28'h0000055; mem_req_ready = 1;
    @(negedge clk);
    #1;
    checkOutput("post-reset mem_req_valid", mem_req_valid, 1);
    checkOutput("post-reset addr", mem_req_addr, 28'h0000055);
    checkOutput("post-reset ic_req_ready", ic_req_ready, 1);
    @(negedge clk);
    ic_req_valid = 0;
    for (int b = 0; b < 4; b++) begin
      mem_resp_valid = 1; mem_resp_data = 128'h90 + 128'(b);
      #1;
      checkOutput("post-reset ic_resp_valid", ic_resp_valid, 1);
      checkOutput("post-reset busy", busy, 1);
      @(negedge clk);
    end
    mem_resp_valid = 0;
    #1;
    checkOutput("post-reset done busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single main-memory port between the instruction cache and the data cache. Each cache issues a line-refill read or a dirty-line writeback on a miss. The block grants one requester at a time, using round-robin on ties. It forwards the latched request, streams write beats or read beats, and returns to idle after the last beat. It sits between the two cache miss interfaces and the memory model. While it serves a cache, that cache's stall is held, and through it the NOP insertion in fetch.

## Interface
- ADDR_W, 28, line address width
- DATA_W, 128, beat width
- BEATS, 4, beats per cache line (power of two, ≥2)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ic_req_valid  in  1  icache read request
- ic_req_addr  in  ADDR_W  icache line address
- ic_req_ready  out  1  icache request accepted this cycle
- ic_resp_valid  out  1  read beat for icache
- ic_resp_data  out  DATA_W  read beat data
- dc_req_valid  in  1  dcache request
- dc_req_rw  in  1  1 = write (writeback), 0 = read
- dc_req_addr  in  ADDR_W  dcache line address
- dc_req_ready  out  1  dcache request accepted this cycle
- dc_wdata_valid  in  1  dcache write beat valid
- dc_wdata  in  DATA_W  write beat
- dc_wdata_ready  out  1  write beat accepted
- dc_resp_valid  out  1  read beat for dcache
- dc_resp_data  out  DATA_W  read beat data
- mem_req_valid  out  1  request to memory
- mem_req_rw  out  1  latched rw
- mem_req_addr  out  ADDR_W  latched address
- mem_req_ready  in  1  memory accepts request
- mem_wdata_valid  out  1  write beat to memory
- mem_wdata  out  DATA_W  write beat
- mem_wdata_ready  in  1  memory accepts beat
- mem_resp_valid  in  1  read beat from memory
- mem_resp_data  in  DATA_W  read beat
- busy  out  1  state ≠ IDLE

## Operation
- FSM states:
  - IDLE: no grant held.
  - REQ: request presented to memory.
  - WDATA: streaming write beats to memory.
  - RDATA: receiving read beats from memory.
- IDLE with a request pending:
  - Register the grant, latch the address, and latch rw (icache rw forced 0).
  - Go to REQ.
  - With no request pending, stay in IDLE.
- Grant rule:
  - Only one requester valid: grant it.
  - Both valid: grant the one not granted last.
  - last_grant updates on every grant.
- REQ: mem_req_valid=1.
  - The granted requester's req_ready = mem_req_ready. The other requester's ready = 0.
  - On handshake: rw=1 → WDATA, rw=0 → RDATA. Beat counter cleared.
- WDATA:
  - mem_wdata_valid = dc_wdata_valid.
  - dc_wdata_ready = mem_wdata_ready.
  - mem_wdata = dc_wdata.
  - Counter increments on each beat handshake. After handshake of beat BEATS-1 → IDLE.
  - Writes produce no response.
- RDATA:
  - The granted requester's resp_valid = mem_resp_valid. The other's = 0.
  - Both resp_data ports carry mem_resp_data.
  - Counter increments per beat. After beat BEATS-1 → IDLE.
- mem_resp_valid outside RDATA is ignored and forwarded nowhere.
- dc_wdata_valid outside WDATA is not accepted (dc_wdata_ready=0).
- Requesters hold valid until ready. A requester dropping valid in REQ does not cancel; the latched request proceeds.
- Counter width: log2(BEATS). Wraps to 0 on the final beat.

## Timing
- Reset (rst_n low, immediate):
  - state=IDLE, counter=0, last_grant=icache, so dcache wins the first tie.
  - Latched addr/rw = 0.
  - All valid/ready/busy outputs = 0.
- Grant latency: request seen in IDLE at cycle t → mem_req_valid at t+1.
- Earliest request acceptance is t+1 (same cycle as mem_req_ready).
- Read beats are forwarded combinationally, with zero added latency.
- After the final beat at cycle n: IDLE at n+1, next mem_req_valid no earlier than n+2. This is one mandatory dead cycle.
- mem_req_ready low holds REQ indefinitely. Latched outputs stay stable.
- Reset asserted mid-burst aborts to IDLE asynchronously. Memory and caches are reset together; no partial-line recovery.
- Request arriving while busy: waits. It is evaluated at the next IDLE cycle.

## Test plan
- Single icache read, addr 0x0000100, mem ready immediately, beats D0..D3 on consecutive cycles:
  - mem_req_valid at t+1 with addr 0x0000100, rw=0.
  - ic_req_ready pulses at t+1.
  - ic_resp_valid for 4 cycles carrying D0..D3; dc_resp_valid stays 0.
  - busy falls after the 4th beat.
- Both request in the same cycle after reset:
  - dcache granted first.
  - After it completes, icache granted at n+2.
  - Repeat with both held high: grants alternate ic/dc/ic.
- dcache writeback, addr 0x0ABCDEF, rw=1, wdata beats W0..W3 with mem_wdata_ready low on beat 1 for 2 cycles:
  - 4 beats delivered in order.
  - Beat 1 held stable during the stall.
  - IDLE after W3; no resp_valid asserted.
- mem_req_ready held low 3 cycles in REQ:
  - addr/rw/mem_req_valid stable.
  - Requester ready low until cycle 4, then a single pulse.
- Spurious mem_resp_valid in IDLE and WDATA: neither ic_resp_valid nor dc_resp_valid asserts.
- rst_n pulled low after read beat 2:
  - Outputs 0 immediately, state IDLE.
  - After release, a new icache request is granted normally with counter starting at 0.
